// File: rtl/echo_fifo.sv
// Byte loopback FIFO between a UART receiver and transmitter.
// The FIFO is show-ahead: the oldest byte is always presented on o_tx_data, and o_tx_stb is high whenever the FIFO holds data.
module echo_fifo #(
  parameter int LGFLEN        = 4,
  parameter bit OPT_DROP_FERR = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rx_stb,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_ferr,
  input  logic              i_rx_break,
  output logic              o_tx_stb,
  output logic [7:0]        o_tx_data,
  input  logic              i_tx_busy,
  input  logic              i_clr_ovfl,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow
);

  localparam int               DEPTH    = 1 << LGFLEN;
  localparam logic [LGFLEN:0]  FULL_CNT = {1'b1, {LGFLEN{1'b0}}};

  logic [7:0]        mem_q [DEPTH];
  logic [LGFLEN-1:0] rptr_q, rptr_d;
  logic [LGFLEN-1:0] wptr_q, wptr_d;
  logic [LGFLEN:0]   fill_q, fill_d;
  logic              empty_q, empty_d;
  logic              full_q, full_d;
  logic              ovfl_q, ovfl_d;

  logic push_req, pop, push, ovfl_set;

  assign push_req = i_rx_stb && !i_rx_break && !(OPT_DROP_FERR && i_rx_ferr);
  assign pop      = !empty_q && !i_tx_busy;
  // When the FIFO is full, the same-cycle pop frees the slot that the incoming byte then takes.
  assign push     = push_req && (!full_q || pop);
  assign ovfl_set = push_req && full_q && !pop;

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    fill_d = fill_q;
    if (push) wptr_d = wptr_q + 1'b1;
    if (pop)  rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
    empty_d = (fill_d == '0);
    full_d  = (fill_d == FULL_CNT);
    ovfl_d  = ovfl_q;
    if (ovfl_set)        ovfl_d = 1'b1;
    else if (i_clr_ovfl) ovfl_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      fill_q  <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovfl_q  <= 1'b0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      fill_q  <= fill_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovfl_q  <= ovfl_d;
    end
  end

  // Storage is not cleared on reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem_q[wptr_q] <= i_rx_data;
  end

  assign o_tx_stb   = !empty_q;
  assign o_tx_data  = mem_q[rptr_q];
  assign o_fill     = fill_q;
  assign o_empty    = empty_q;
  assign o_full     = full_q;
  assign o_overflow = ovfl_q;

endmodule

// File: tb/tb_echo_fifo.sv
// Self-checking bench for echo_fifo (LGFLEN=4, OPT_DROP_FERR=1).
// The reference model is a byte queue plus a sticky overflow flag.
module tb_echo_fifo;

  localparam int LGFLEN = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_stb, rx_ferr, rx_break, tx_busy, clr_ovfl;
  logic [7:0]        rx_data;
  logic              tx_stb;
  logic [7:0]        tx_data;
  logic [LGFLEN:0]   fill;
  logic              empty, full, ovfl;

  int passed = 0;
  int total  = 0;

  byte unsigned ref_q[$];
  bit           ref_ovfl;

  echo_fifo #(.LGFLEN(LGFLEN), .OPT_DROP_FERR(1'b1)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_rx_stb   (rx_stb),
    .i_rx_data  (rx_data),
    .i_rx_ferr  (rx_ferr),
    .i_rx_break (rx_break),
    .o_tx_stb   (tx_stb),
    .o_tx_data  (tx_data),
    .i_tx_busy  (tx_busy),
    .i_clr_ovfl (clr_ovfl),
    .o_fill     (fill),
    .o_empty    (empty),
    .o_full     (full),
    .o_overflow (ovfl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_state();
    int n;
    n = ref_q.size();
    check("fill",     32'(fill),   32'(n));
    check("empty",    32'(empty),  32'(n == 0));
    check("full",     32'(full),   32'(n == DEPTH));
    check("tx_stb",   32'(tx_stb), 32'(n != 0));
    check("overflow", 32'(ovfl),   32'(ref_ovfl));
    if (n != 0) check("tx_data", 32'(tx_data), 32'(ref_q[0]));
  endtask

  // One clock: drive inputs, advance the model, check after the edge.
  task automatic cycle(input bit stb, input byte unsigned d, input bit ferr, input bit brk,
                       input bit busy, input bit clr);
    bit accept, do_pop;
    @(negedge clk);
    rst = 1'b0; rx_stb = stb; rx_data = d; rx_ferr = ferr; rx_break = brk;
    tx_busy = busy; clr_ovfl = clr;
    accept = stb && !brk && !ferr;
    do_pop = (ref_q.size() != 0) && !busy;
    if (do_pop) void'(ref_q.pop_front());
    if (accept && (ref_q.size() < DEPTH)) ref_q.push_back(d);
    if (accept && (ref_q.size() == DEPTH) && !do_pop && !(ref_q.size() < DEPTH)) begin
      // model was full before this edge only if no slot was freed and none taken now
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic cycle_ovfl_aware(input bit stb, input byte unsigned d, input bit busy, input bit clr);
    bit was_full, do_pop, accept;
    @(negedge clk);
    rst = 1'b0; rx_stb = stb; rx_data = d; rx_ferr = 1'b0; rx_break = 1'b0;
    tx_busy = busy; clr_ovfl = clr;
    accept   = stb;
    was_full = (ref_q.size() == DEPTH);
    do_pop   = (ref_q.size() != 0) && !busy;
    if (do_pop) void'(ref_q.pop_front());
    if (accept && (!was_full || do_pop)) ref_q.push_back(d);
    if (accept && was_full && !do_pop) ref_ovfl = 1'b1;
    else if (clr)                      ref_ovfl = 1'b0;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input bit stb);
    @(negedge clk);
    rst = 1'b1; rx_stb = stb; rx_data = 8'hEE; rx_ferr = 1'b0; rx_break = 1'b0;
    tx_busy = 1'b0; clr_ovfl = 1'b1;
    ref_q.delete();
    ref_ovfl = 1'b0;
    @(posedge clk);
    #1;
    check_state();
  endtask

  initial begin
    int pushed;
    rst = 1'b1; rx_stb = 1'b0; rx_data = '0; rx_ferr = 1'b0; rx_break = 1'b0;
    tx_busy = 1'b0; clr_ovfl = 1'b0; ref_ovfl = 1'b0;

    // Reset, then single byte 0x41 pushed at edge 5.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);
    cycle_ovfl_aware(1'b1, 8'h41, 1'b0, 1'b0);
    check("single_stb",  32'(tx_stb),  32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);
    check("single_empty", 32'(empty), 32'd1);

    // Backpressure: fill to depth with 0x01..0x10.
    for (int i = 1; i <= DEPTH; i++) cycle_ovfl_aware(1'b1, 8'(i), 1'b1, 1'b0);
    check("bp_full", 32'(full), 32'd1);
    check("bp_fill", 32'(fill), 32'd16);
    check("bp_ovfl", 32'(ovfl), 32'd0);
    for (int i = 0; i < 3; i++) cycle_ovfl_aware(1'b0, 8'h00, 1'b1, 1'b0);

    // Overflow, clear, then overflow coincident with clear.
    cycle_ovfl_aware(1'b1, 8'hAA, 1'b1, 1'b0);
    check("ovfl_set",  32'(ovfl), 32'd1);
    check("ovfl_fill", 32'(fill), 32'd16);
    cycle_ovfl_aware(1'b0, 8'h00, 1'b1, 1'b1);
    check("ovfl_clr", 32'(ovfl), 32'd0);
    cycle_ovfl_aware(1'b1, 8'hAB, 1'b1, 1'b1);
    check("ovfl_set_wins", 32'(ovfl), 32'd1);
    cycle_ovfl_aware(1'b0, 8'h00, 1'b1, 1'b1);

    // Full with simultaneous push and pop: 0x55 goes in last.
    cycle_ovfl_aware(1'b1, 8'h55, 1'b0, 1'b0);
    check("fullpp_fill", 32'(fill), 32'd16);
    check("fullpp_ovfl", 32'(ovfl), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);
    check("fullpp_last", 32'(tx_data), 32'h55);
    cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);

    // Filtering: framing error and break are not stored; break still drains.
    cycle_ovfl_aware(1'b1, 8'h11, 1'b1, 1'b0);
    cycle_ovfl_aware(1'b1, 8'h22, 1'b1, 1'b0);
    cycle(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0);
    check("ferr_fill", 32'(fill), 32'd2);
    cycle(1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0);
    check("break_fill", 32'(fill), 32'd2);
    cycle(1'b1, 8'h45, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h46, 1'b0, 1'b1, 1'b0, 1'b0);
    check("break_drain", 32'(empty), 32'd1);

    // Random stream of 40 bytes with random backpressure, then drain.
    pushed = 0;
    while (pushed < 40) begin
      bit s;
      s = ($urandom_range(0, 3) != 0);
      if (s) pushed++;
      cycle_ovfl_aware(s, 8'($urandom), bit'($urandom_range(0, 2) == 0), 1'b0);
    end
    for (int i = 0; i < 20; i++) cycle_ovfl_aware(1'b0, 8'h00, bit'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < DEPTH + 2; i++) cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);
    check("rand_drained", 32'(empty), 32'd1);

    // Mid-stream reset with seven bytes stored and a push pending.
    for (int i = 0; i < 7; i++) cycle_ovfl_aware(1'b1, 8'(8'hC0 + i), 1'b1, 1'b0);
    check("pre_reset_fill", 32'(fill), 32'd7);
    do_reset(1'b1);
    check("reset_fill",   32'(fill),   32'd0);
    check("reset_tx_stb", 32'(tx_stb), 32'd0);
    check("reset_ovfl",   32'(ovfl),   32'd0);
    cycle_ovfl_aware(1'b0, 8'h00, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/echo_fifo.md
ECHO_FIFO -- requirements
Module: echo_fifo

Interface
REQ-001 SHALL have parameter LGFLEN, default 4: log2 of FIFO depth; depth = 2^LGFLEN bytes; legal range 2..10.
REQ-002 SHALL have parameter OPT_DROP_FERR, default 1: when 1, bytes received with a framing error are discarded.
REQ-003 Port i_clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port i_reset  input  1: synchronous, active-high reset.
REQ-005 Port i_rx_stb  input  1: one-cycle strobe from the receiver; i_rx_data is valid this cycle.
REQ-006 Port i_rx_data  input  8: received byte.
REQ-007 Port i_rx_ferr  input  1: framing error for the byte on i_rx_data; qualified by i_rx_stb.
REQ-008 Port i_rx_break  input  1: line-break indication from the receiver (level).
REQ-009 Port o_tx_stb  output  1: a byte is offered to the transmitter.
REQ-010 Port o_tx_data  output  8: byte offered to the transmitter.
REQ-011 Port i_tx_busy  input  1: transmitter busy; the offered byte is not taken while high.
REQ-012 Port i_clr_ovfl  input  1: one-cycle request to clear o_overflow.
REQ-013 Port o_fill  output  LGFLEN+1: number of bytes currently stored, 0..2^LGFLEN.
REQ-014 Port o_empty  output  1: high when o_fill == 0.
REQ-015 Port o_full  output  1: high when o_fill == 2^LGFLEN.
REQ-016 Port o_overflow  output  1: sticky flag; at least one byte was dropped because the FIFO was full.

Function
REQ-017 Push condition: i_rx_stb && !i_rx_break && !(OPT_DROP_FERR && i_rx_ferr).
REQ-018 Pop condition: o_tx_stb && !i_tx_busy. This is the accept handshake; the byte is consumed on that edge.
REQ-019 Storage: circular buffer with LGFLEN-bit read and write pointers, each wrapping modulo 2^LGFLEN; fill tracked as an LGFLEN+1-bit count.
REQ-020 Show-ahead output: o_tx_stb = !o_empty; o_tx_data = oldest stored byte.
REQ-021 o_tx_data SHALL hold stable while o_tx_stb is high and no pop occurs.
REQ-022 Latency: a byte pushed at edge N SHALL appear on o_tx_data with o_tx_stb high in the cycle after edge N (one cycle); there is no same-cycle bypass.
REQ-023 Push only, not full: write at wptr; wptr+1; fill+1.
REQ-024 Pop only: rptr+1; fill-1.
REQ-025 Push and pop in the same cycle, fill between 1 and depth inclusive: both execute; fill unchanged.
REQ-026 Push when full with a same-cycle pop: the push is accepted, fill stays at depth, and o_overflow is not set.
REQ-027 Push when full with no pop: the byte is dropped, pointers and fill are unchanged, and o_overflow is set to 1 at the next edge.
REQ-028 Push when empty with no pop: normal push; pop is impossible because o_tx_stb is low.
REQ-029 While i_rx_break is high, no pushes occur. Stored bytes continue to drain.
REQ-030 o_overflow clears on i_clr_ovfl. If a new overflow occurs in the same cycle as i_clr_ovfl, set wins and o_overflow stays 1.
REQ-031 o_fill, o_empty and o_full SHALL be registered and consistent with each other in every cycle.

Reset
REQ-032 When i_reset is high at an edge: rptr=0, wptr=0, fill=0, o_empty=1, o_full=0, o_tx_stb=0, o_overflow=0. Memory contents are not cleared.
REQ-033 Reset overrides any push, pop or clear in the same cycle.
REQ-034 A reset asserted mid-stream discards all stored bytes; o_tx_stb is low in the cycle after reset.
REQ-035 o_tx_data is don't-care while o_tx_stb is low.

Verification
REQ-036 Single byte: reset; i_rx_stb with 0x41 at edge 5, i_tx_busy=0 -> o_tx_stb=1 and o_tx_data=0x41 in cycle 6; popped at edge 6; o_empty=1 after.
REQ-037 Backpressure and order: i_tx_busy=1; push 0x01..0x10 (16 bytes, LGFLEN=4) -> o_full=1, o_fill=16, o_overflow=0; release busy -> bytes emerge 0x01..0x10 in order; o_tx_data stable while busy.
REQ-038 Overflow: FIFO full, busy=1, push 0xAA -> dropped, o_overflow=1, o_fill=16; i_clr_ovfl pulse -> o_overflow=0; simultaneous overflow and clear -> o_overflow stays 1.
REQ-039 Full with simultaneous push and pop: fill=16, push 0x55 and pop on the same edge -> fill=16, o_overflow=0, and 0x55 emerges last.
REQ-040 Filtering: push with i_rx_ferr=1 (OPT_DROP_FERR=1) -> not stored; push with i_rx_break=1 -> not stored; o_fill unchanged in both cases.
REQ-041 Wrap and reset: stream 40 bytes with random busy and compare against a reference queue, covering pointer wrap; assert i_reset with fill=7 -> next cycle o_fill=0, o_tx_stb=0, o_overflow=0.
